multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the CPU datapath.
- Holds the instruction register and the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine.
- Drives the 3-bit select lines of the datapath's 8:1 operand and write-back multiplexers, plus the ALU, register-file, PC and memory strobes.
- Sits directly upstream of the operand muxes; their select inputs come only from this block.

Parameters:
- IW, 16, instruction width. Fields are fixed at the top 16 bits; IW must be ≥ 16.
- NOP_OP, 4'h0, opcode value forced into the IR on reset.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_rdata  in  IW  memory read data; sampled when mem_req && mem_ready.
- mem_ready  in  1  memory handshake; the current access completes in this cycle.
- alu_zero  in  1  ALU zero flag; sampled in EXECUTE.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (store).
- addr_sel  out  1  0 = PC drives the address, 1 = ALU result drives it.
- sel_a  out  3  operand-A mux select.
- sel_b  out  3  operand-B mux select.
- wb_sel  out  3  write-back mux select: 0 = ALU, 1 = zero-extended imm, 2 = mem_rdata.
- alu_op  out  4  ALU function: 0 PASS_A, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  3  register-file write address.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= branch/jump target (computed externally).
- halted  out  1  core halted.
- trap  out  1  illegal-opcode trap; exists only with the feature enabled.

Behaviour:
- Reset (async, rst_n = 0): state = FETCH, IR = {NOP_OP, zeros}. All strobes (mem_req excluded, see FETCH), halted and trap are 0. sel_a, sel_b, wb_sel, alu_op and rf_waddr are 0.
- Reset asserted mid-instruction aborts it: no rf_we, mem_we or pc_load after assertion.
- Instruction fields: op = IR[15:12], rd = IR[11:9], ra = IR[8:6], rb = IR[5:3], imm = IR[5:0].
- Outputs are combinational from (state, IR, alu_zero, mem_ready) only; mem_rdata never feeds an output combinationally.
- sel_a = ra and sel_b = rb in every state except FETCH, where both are 0.
- rf_waddr = rd.
- FETCH:
  - mem_req = 1, addr_sel = 0.
  - Stalls while mem_ready = 0.
  - On mem_ready = 1: IR <= mem_rdata, pc_inc = 1, next state DECODE.
- DECODE:
  - op 0 NOP -> FETCH.
  - op 1-5 (ADD, SUB, AND, OR, XOR) -> EXECUTE.
  - op 6 LDI -> WRITEBACK.
  - op 7 LD, 8 ST, 9 BEQZ -> EXECUTE.
  - op A JMP: pc_load = 1 -> FETCH.
  - op F HLT -> HALT.
  - All other opcodes -> FETCH, treated as NOP.
- EXECUTE:
  - ALU ops: alu_op = op, next WRITEBACK.
  - LD/ST: alu_op = ADD (ra + imm supplied externally), next MEMORY.
  - BEQZ: alu_op = PASS_A; pc_load = alu_zero; next FETCH.
- MEMORY:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for ST only.
  - Stalls while mem_ready = 0.
  - On mem_ready = 1: ST -> FETCH; LD -> WRITEBACK with mem_rdata captured internally as the write-back value.
- WRITEBACK:
  - rf_we = 1 for exactly one cycle.
  - wb_sel = 0 for ALU ops, 1 for LDI, 2 for LD.
  - alu_op is held from EXECUTE.
  - Next state FETCH.
- HALT: halted = 1, all strobes 0, state is sticky until reset.
- Latency in cycles, with zero memory wait:

  | Instruction | Cycles |
  |---|---|
  | NOP, JMP | 2 |
  | LDI, BEQZ | 3 |
  | ALU ops, ST | 4 |
  | LD | 5 |

  Each memory wait cycle adds 1.
- Strobes are mutually consistent:
  - rf_we, pc_inc and pc_load are never 1 in the same cycle.
  - mem_we implies mem_req.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Undefined opcodes in DECODE go to state TRAP.
  - In TRAP: trap = 1, all strobes 0, sticky until reset.
  - The trap port exists.
- Undefined:
  - Undefined opcodes behave as NOP (DECODE -> FETCH, 2 cycles).
  - No trap port, no TRAP state.

Test Plan:
- Reset behaviour: assert rst_n = 0 mid-EXECUTE of an ADD.
  - Expected: state = FETCH at once; rf_we never pulses; IR opcode = 0.
- ADD, zero-wait memory: fetch 16'h1A4C (ADD rd=5, ra=1, rb=1).
  - Expected: pc_inc in cycle 1; sel_a = 1 and sel_b = 1 from cycle 2; alu_op = 1 in cycle 3; rf_we = 1, wb_sel = 0, rf_waddr = 5 in cycle 4; FETCH in cycle 5.
- LD with 2 wait states in MEMORY: fetch 16'h7243.
  - Expected: mem_req = 1 and addr_sel = 1 held for 3 cycles.
  - Expected: WRITEBACK follows with wb_sel = 2, rf_waddr = 1, rf_we = 1.
  - Expected: total 7 cycles.
- BEQZ: issue it twice, with alu_zero = 1 and then 0.
  - Expected: pc_load = 1 in EXECUTE only for the alu_zero = 1 case; 3 cycles each.
- HLT 16'hF000.
  - Expected: halted = 1 two cycles after the fetch starts, stays 1 for 20+ cycles, mem_req = 0; cleared only by rst_n.
- Illegal opcode 16'hB000.
  - With CTRL_ILLEGAL_TRAP_EN: trap = 1, sticky.
  - Without: FETCH two cycles later, trap absent.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multi-cycle sequencer.
// Latency: none. The interface holds wires only.
// Backpressure: mem_ready from the memory side stalls the sequencer's memory phases.
// Ports: the master modport belongs to the control unit. It takes mem_rdata, mem_ready and alu_zero,
// and it drives the memory strobes, the mux selects, the ALU function, the RF write and the PC strobes.
// The slave modport is the datapath/memory side of the same signals.
// The trap signal is present only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int unsigned IW = 16
);
    logic [IW-1:0] mem_rdata;
    logic          mem_ready;
    logic          alu_zero;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel;
    logic [2:0]    sel_a;
    logic [2:0]    sel_b;
    logic [2:0]    wb_sel;
    logic [3:0]    alu_op;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic          pc_inc;
    logic          pc_load;
    logic          halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic          trap;
`endif

    modport master (
        input  mem_rdata,
        input  mem_ready,
        input  alu_zero,
        output mem_req,
        output mem_we,
        output addr_sel,
        output sel_a,
        output sel_b,
        output wb_sel,
        output alu_op,
        output rf_we,
        output rf_waddr,
        output pc_inc,
        output pc_load,
        output halted
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output trap
`endif
    );

    modport slave (
        output mem_rdata,
        output mem_ready,
        output alu_zero,
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        input  sel_a,
        input  sel_b,
        input  wb_sel,
        input  alu_op,
        input  rf_we,
        input  rf_waddr,
        input  pc_inc,
        input  pc_load,
        input  halted
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input  trap
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU sequencer. It holds the IR and the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM.
// Latency: with zero wait, NOP/JMP take 2 cycles, LDI/BEQZ 3, ALU/ST 4 and LD 5. Each memory wait cycle adds 1.
// Backpressure: FETCH and MEMORY hold their state and strobes while mem_ready is 0.
// Ports: clk, rst_n (asynchronous, active-low), and bus (multicycle_control_unit_if.master).
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes enter a sticky TRAP state with trap = 1.
// Without the macro, undefined opcodes execute as NOP.
// The instruction fields sit in the top 16 bits of the IR, so IW must be at least 16.
module multicycle_control_unit #(
    parameter int unsigned IW     = 16,
    parameter logic [3:0]  NOP_OP = 4'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic [IW-1:0] wb_data;

    logic [15:0] fld;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        is_alu;

    assign fld    = ir[IW-1 -: 16];
    assign op     = fld[15:12];
    assign rd     = fld[11:9];
    assign ra     = fld[8:6];
    assign rb     = fld[5:3];
    assign is_alu = (op >= 4'd1) && (op <= 4'd5);

    // The load data register feeds the write-back path of the surrounding datapath.
    // The low immediate bits are consumed there as well. Neither drives a control output.
    logic unused_bits;
    assign unused_bits = ^{wb_data, ir};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= {NOP_OP, {(IW-4){1'b0}}};
            wb_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && bus.mem_ready) begin
                ir <= bus.mem_rdata;
            end
            if (state == S_MEMORY && bus.mem_ready && op == OP_LD) begin
                wb_data <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.wb_sel   = 3'd0;
        bus.alu_op   = ALU_PASS_A;
        bus.rf_we    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.halted   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.trap     = 1'b0;
`endif
        // The operand muxes follow the IR everywhere except FETCH.
        // In FETCH the IR is still the previous instruction.
        bus.sel_a    = (state == S_FETCH) ? 3'd0 : ra;
        bus.sel_b    = (state == S_FETCH) ? 3'd0 : rb;
        bus.rf_waddr = rd;

        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.pc_inc = 1'b1;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu || op == OP_LD || op == OP_ST || op == OP_BEQZ) begin
                    state_nxt = S_EXECUTE;
                end else if (op == OP_LDI) begin
                    state_nxt = S_WRITEBACK;
                end else if (op == OP_JMP) begin
                    bus.pc_load = 1'b1;
                    state_nxt   = S_FETCH;
                end else if (op == OP_HLT) begin
                    state_nxt = S_HALT;
                end else if (op == OP_NOP) begin
                    state_nxt = S_FETCH;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_FETCH;
`endif
                end
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    bus.alu_op = op;
                    state_nxt  = S_WRITEBACK;
                end else if (op == OP_LD || op == OP_ST) begin
                    bus.alu_op = ALU_ADD;
                    state_nxt  = S_MEMORY;
                end else begin
                    // BEQZ is the only other opcode that can arrive here.
                    bus.alu_op  = ALU_PASS_A;
                    bus.pc_load = (op == OP_BEQZ) && bus.alu_zero;
                    state_nxt   = S_FETCH;
                end
            end
            S_MEMORY: begin
                // Keep the address add alive so the ALU result stays on the address bus during wait states.
                bus.alu_op   = ALU_ADD;
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (op == OP_ST);
                if (bus.mem_ready) begin
                    state_nxt = (op == OP_ST) ? S_FETCH : S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                bus.rf_we = 1'b1;
                if (op == OP_LDI) begin
                    bus.wb_sel = 3'd1;
                end else if (op == OP_LD) begin
                    bus.wb_sel = 3'd2;
                end
                // Present the same ALU function that EXECUTE used, so the result stays stable.
                if (is_alu) begin
                    bus.alu_op = op;
                end else if (op == OP_LD) begin
                    bus.alu_op = ALU_ADD;
                end
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                bus.trap = 1'b1;
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit. Directed reset/ADD/HLT/illegal checks, then a random instruction stream.
// A per-instruction model pushes expected retire records, and a monitor closes each record at the next fetch.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled on the falling edge.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.IW(16)) bus ();

    multicycle_control_unit #(.IW(16), .NOP_OP(4'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        bit          z;
    } plan_t;

    typedef struct {
        int cycles;
        int pc_loads;
        int writes;
        int waddr;
        int wb_sel;
        int wb_alu;
        int mem_cycles;
        int we_cycles;
        int ra;
        int rb;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    int  tests   = 0;
    int  failed  = 0;
    int  retired = 0;
    bit  mon_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected retire record, derived from the instruction-class latency table.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        int   op;
        bit   alu, ldi, ld, st, beqz, jmp;
        op   = int'(p.instr[15:12]);
        alu  = (op >= 1 && op <= 5);
        ldi  = (op == 6);
        ld   = (op == 7);
        st   = (op == 8);
        beqz = (op == 9);
        jmp  = (op == 10);
        if (alu || st)       e.cycles = 4;
        else if (ld)         e.cycles = 5;
        else if (ldi || beqz) e.cycles = 3;
        else                 e.cycles = 2;
        e.cycles += p.fw;
        if (ld || st) e.cycles += p.mw;
        e.pc_loads   = (jmp || (beqz && p.z)) ? 1 : 0;
        e.writes     = (alu || ldi || ld) ? 1 : 0;
        e.waddr      = int'(p.instr[11:9]);
        e.wb_sel     = ldi ? 1 : (ld ? 2 : 0);
        e.wb_alu     = alu ? op : (ld ? 1 : -1);
        e.mem_cycles = (ld || st) ? p.mw + 1 : 0;
        e.we_cycles  = st ? p.mw + 1 : 0;
        e.ra         = int'(p.instr[8:6]);
        e.rb         = int'(p.instr[5:3]);
        return e;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        logic [3:0]  op;
        logic [11:0] body;
`ifdef CTRL_ILLEGAL_TRAP_EN
        op = 4'($urandom_range(0, 10));
`else
        op = 4'($urandom_range(0, 14));
`endif
        body    = 12'($urandom);
        p.instr = {op, body};
        p.fw    = $urandom_range(0, 2);
        p.mw    = $urandom_range(0, 3);
        p.z     = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic plan_t mk(input logic [15:0] instr, input int fw, input int mw, input bit z);
        plan_t p;
        p.instr = instr;
        p.fw    = fw;
        p.mw    = mw;
        p.z     = z;
        return p;
    endfunction

    // Monitor: one record per instruction, from its first fetch cycle up to the next fetch.
    initial begin
        int  cyc, inc_n, ld_n, wr_n, wr_addr, wr_sel, wr_alu, mem_n, we_n, viol, sa, sb;
        bit  open, body, sel_seen, sel_var, fetch;
        exp_t e;
        open = 1'b0;
        body = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                open = 1'b0;
            end else begin
                fetch = bus.mem_req && !bus.addr_sel;
                if (fetch && open && body) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycles", cyc, e.cycles);
                        chk("pc_inc_count", inc_n, 1);
                        chk("pc_load_count", ld_n, e.pc_loads);
                        chk("rf_we_count", wr_n, e.writes);
                        if (e.writes != 0) begin
                            chk("rf_waddr", wr_addr, e.waddr);
                            chk("wb_sel", wr_sel, e.wb_sel);
                            if (e.wb_alu >= 0) chk("wb_alu_op", wr_alu, e.wb_alu);
                        end
                        chk("mem_data_cycles", mem_n, e.mem_cycles);
                        chk("mem_we_cycles", we_n, e.we_cycles);
                        chk("strobe_violations", viol, 0);
                        chk("sel_a", sa, e.ra);
                        chk("sel_b", sb, e.rb);
                        chk("sel_stable", int'(sel_var), 0);
                    end
                    retired++;
                    open = 1'b0;
                end
                if (!open && fetch) begin
                    open = 1'b1; body = 1'b0; sel_seen = 1'b0; sel_var = 1'b0;
                    cyc = 0; inc_n = 0; ld_n = 0; wr_n = 0; wr_addr = 0; wr_sel = 0;
                    wr_alu = 0; mem_n = 0; we_n = 0; viol = 0; sa = -1; sb = -1;
                end
                if (open) begin
                    cyc++;
                    inc_n += int'(bus.pc_inc);
                    ld_n  += int'(bus.pc_load);
                    if (bus.rf_we) begin
                        wr_n++;
                        wr_addr = int'(bus.rf_waddr);
                        wr_sel  = int'(bus.wb_sel);
                        wr_alu  = int'(bus.alu_op);
                    end
                    if (bus.mem_req && bus.addr_sel) mem_n++;
                    if (bus.mem_we) we_n++;
                    if ((int'(bus.rf_we) + int'(bus.pc_inc) + int'(bus.pc_load)) > 1) viol++;
                    if (bus.mem_we && !bus.mem_req) viol++;
                    if (bus.halted) viol++;
                    if (fetch) begin
                        if (bus.sel_a != 3'd0 || bus.sel_b != 3'd0) viol++;
                    end else begin
                        body = 1'b1;
                        if (!sel_seen) begin
                            sa = int'(bus.sel_a);
                            sb = int'(bus.sel_b);
                            sel_seen = 1'b1;
                        end else if (sa != int'(bus.sel_a) || sb != int'(bus.sel_b)) begin
                            sel_var = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic run_stream(input int total);
        int    issued = 0;
        int    fcnt = 0;
        int    mcnt = 0;
        int    budget = 0;
        bit    fetching = 1'b0;
        plan_t cur;
        cur = mk(16'h0000, 0, 0, 1'b0);
        while (retired < total && budget < 20000) begin
            if (bus.mem_req && !bus.addr_sel) begin
                if (!fetching && issued < total) begin
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur = rand_plan();
                    exp_q.push_back(model(cur));
                    issued++;
                    fetching = 1'b1;
                    fcnt = 0;
                    mcnt = 0;
                end
                bus.mem_rdata = cur.instr;
                if (!fetching) begin
                    bus.mem_ready = 1'b0;
                end else if (fcnt < cur.fw) begin
                    bus.mem_ready = 1'b0;
                    fcnt++;
                end else begin
                    bus.mem_ready = 1'b1;
                    fetching = 1'b0;
                end
            end else if (bus.mem_req) begin
                bus.mem_rdata = 16'($urandom);
                if (mcnt < cur.mw) begin
                    bus.mem_ready = 1'b0;
                    mcnt++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            bus.alu_zero = cur.z;
            tick();
            budget++;
        end
        chk("stream_retired", retired, total);
        chk("stream_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.alu_zero  = 1'b0;
        #3;
        chk("reset_strobes",
            int'({bus.mem_req, bus.mem_we, bus.addr_sel, bus.rf_we, bus.pc_inc, bus.pc_load, bus.halted}),
            int'(7'b1000000));
        chk("reset_selects",
            int'({bus.sel_a, bus.sel_b, bus.wb_sel, bus.alu_op, bus.rf_waddr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD r5, r1, r1 with zero-wait memory, checked cycle by cycle.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1A4C;
        #1;
        chk("add_c1_pc_inc", int'(bus.pc_inc), 1);
        chk("add_c1_sel_a", int'(bus.sel_a), 0);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("add_c2_sels", int'({bus.sel_a, bus.sel_b}), int'({3'd1, 3'd1}));
        chk("add_c2_pc_inc", int'(bus.pc_inc), 0);
        tick();
        chk("add_c3_alu_op", int'(bus.alu_op), 1);
        tick();
        chk("add_c4_wb", int'({bus.rf_we, bus.wb_sel, bus.rf_waddr}), int'({1'b1, 3'd0, 3'd5}));
        tick();
        chk("add_c5_fetch", int'({bus.mem_req, bus.addr_sel, bus.rf_we}), int'(3'b100));

        // Reset asserted mid-EXECUTE of an ADD aborts it.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1A4C;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("abort_pre_alu_op", int'(bus.alu_op), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_fetch", int'({bus.mem_req, bus.addr_sel}), int'(2'b10));
        chk("abort_ir_cleared", int'({bus.rf_waddr, bus.alu_op}), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rf_we || bus.mem_we || bus.pc_load) bad++;
            tick();
        end
        chk("abort_no_strobes", bad, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed items, then random instructions through the scoreboard.
        plan_q.push_back(mk(16'h1A4C, 0, 0, 1'b0));
        plan_q.push_back(mk(16'h7243, 0, 2, 1'b0));
        plan_q.push_back(mk(16'h9040, 0, 0, 1'b1));
        plan_q.push_back(mk(16'h9040, 0, 0, 1'b0));
        plan_q.push_back(mk(16'hA000, 1, 0, 1'b0));
        plan_q.push_back(mk(16'h6E15, 0, 0, 1'b0));
        plan_q.push_back(mk(16'h8298, 2, 1, 1'b0));
        plan_q.push_back(mk(16'h0000, 0, 0, 1'b0));
`ifndef CTRL_ILLEGAL_TRAP_EN
        plan_q.push_back(mk(16'hB000, 0, 0, 1'b0));
`endif
        mon_en = 1'b1;
        run_stream(160);
        mon_en = 1'b0;

        // HLT is sticky until reset.
        do_reset();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hF000;
        tick();
        bus.mem_ready = 1'b0;
        chk("hlt_decode_not_halted", int'(bus.halted), 0);
        tick();
        chk("hlt_halted", int'(bus.halted), 1);
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (!bus.halted || bus.mem_req || bus.pc_inc || bus.rf_we || bus.pc_load) bad++;
            tick();
        end
        chk("hlt_sticky", bad, 0);
        rst_n = 1'b0;
        #1;
        chk("hlt_cleared_by_reset", int'(bus.halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Illegal opcode.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hB000;
        tick();
        bus.mem_ready = 1'b0;
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal_trap", int'(bus.trap), 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (!bus.trap || bus.mem_req || bus.pc_inc || bus.rf_we) bad++;
            tick();
        end
        chk("illegal_trap_sticky", bad, 0);
`else
        chk("illegal_back_to_fetch", int'({bus.mem_req, bus.addr_sel, bus.halted}), int'(3'b100));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
